// File: rtl/timer_pkg.sv
// Shared definitions for the timer peripheral: register offsets, CTRL/STATUS
// bit positions and the FSM state encoding.
package timer_pkg;

  localparam int unsigned REG_OFF_W = 2;
  localparam int unsigned PRESC_W   = 16;

  localparam logic [REG_OFF_W-1:0] OFF_CTRL   = 2'd0;
  localparam logic [REG_OFF_W-1:0] OFF_PERIOD = 2'd1;
  localparam logic [REG_OFF_W-1:0] OFF_COUNT  = 2'd2;
  localparam logic [REG_OFF_W-1:0] OFF_STATUS = 2'd3;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_AUTO_BIT   = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 2;
  localparam int unsigned STATUS_EXP_BIT  = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: free-runs 0..PRESCALE-1 while i_run is high and flags the last
// count with a one-cycle tick; forced to 0 whenever i_run is low.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_tick_c
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  assign o_tick_c = i_run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!i_run || o_tick_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_periph.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes.
// Optional interrupt output and CTRL.IRQ_EN bit enabled by TIMER_PERIPH_IRQ_EN.
module timer_periph
  import timer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned PRESCALE   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cs,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_wr,
  input  logic                  i_rd,
  inout  wire  [DATA_WIDTH-1:0] io_data_bus,
  output logic                  o_irq
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  timer_state_e          state_q;
  logic                  en_q;
  logic                  auto_q;
  logic [DATA_WIDTH-1:0] period_q;
  logic [DATA_WIDTH-1:0] count_q;
  logic                  expired_q;
  logic                  reload_pend_q;
  logic                  tick;

  logic [ADDR_WIDTH-1:0] addr_off;
  logic [REG_OFF_W-1:0]  reg_sel;
  logic                  in_range;
  logic                  wr_en;
  logic                  rd_en;
  logic                  wr_ctrl;
  logic                  wr_period;
  logic                  wr_status;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  // Address decode; simultaneous read and write strobes are not an access.
  assign addr_off  = i_addr - BASE;
  assign reg_sel   = addr_off[REG_OFF_W-1:0];
  assign in_range  = i_cs && (i_addr >= BASE) && (addr_off < ADDR_WIDTH'(4));
  assign wr_en     = in_range && i_wr && !i_rd;
  assign rd_en     = in_range && i_rd && !i_wr;
  assign wr_ctrl   = wr_en && (reg_sel == OFF_CTRL);
  assign wr_period = wr_en && (reg_sel == OFF_PERIOD);
  assign wr_status = wr_en && (reg_sel == OFF_STATUS);
  assign wdata     = io_data_bus;

  timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_run   (state_q == ST_RUN),
    .o_tick_c(tick)
  );

`ifdef TIMER_PERIPH_IRQ_EN
  logic irq_en_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      irq_en_q <= 1'b0;
    end else if (wr_ctrl) begin
      irq_en_q <= wdata[CTRL_IRQ_EN_BIT];
    end
  end

  assign o_irq = expired_q && irq_en_q;
`else
  assign o_irq = 1'b0;
`endif

  // Control FSM and counter. Expiry is evaluated after the STATUS clear so a
  // coincident expiry leaves the flag set.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q       <= ST_IDLE;
      en_q          <= 1'b0;
      auto_q        <= 1'b0;
      period_q      <= '0;
      count_q       <= '0;
      expired_q     <= 1'b0;
      reload_pend_q <= 1'b0;
    end else begin
      if (wr_period) begin
        period_q <= wdata;
      end
      if (wr_ctrl) begin
        en_q   <= wdata[CTRL_EN_BIT];
        auto_q <= wdata[CTRL_AUTO_BIT];
      end
      if (wr_status && wdata[STATUS_EXP_BIT]) begin
        expired_q <= 1'b0;
      end

      if (wr_ctrl && !wdata[CTRL_EN_BIT]) begin
        state_q       <= ST_IDLE;
        reload_pend_q <= 1'b0;
      end else if (wr_ctrl && (state_q != ST_RUN)) begin
        state_q       <= ST_RUN;
        count_q       <= period_q;
        reload_pend_q <= 1'b0;
      end else if ((state_q == ST_RUN) && tick) begin
        if (reload_pend_q) begin
          count_q       <= period_q;
          reload_pend_q <= 1'b0;
        end else if (count_q == '0) begin
          expired_q <= 1'b1;
          state_q   <= ST_EXPIRED;
        end else if (count_q == DATA_WIDTH'(1)) begin
          count_q   <= '0;
          expired_q <= 1'b1;
          if (auto_q) begin
            reload_pend_q <= 1'b1;
          end else begin
            state_q <= ST_EXPIRED;
          end
        end else begin
          count_q <= count_q - DATA_WIDTH'(1);
        end
      end
    end
  end

  // Combinational read mux; unused bits read as zero.
  always_comb begin
    rdata = '0;
    case (reg_sel)
      OFF_CTRL: begin
        rdata[CTRL_EN_BIT]   = en_q;
        rdata[CTRL_AUTO_BIT] = auto_q;
`ifdef TIMER_PERIPH_IRQ_EN
        rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
`endif
      end
      OFF_PERIOD: rdata = period_q;
      OFF_COUNT:  rdata = count_q;
      OFF_STATUS: rdata[STATUS_EXP_BIT] = expired_q;
      default:    rdata = '0;
    endcase
  end

  assign io_data_bus = rd_en ? rdata : {DATA_WIDTH{1'bz}};

endmodule
